cpu_mem_arbiter: RTL and testbench
==================================

// Module: cpu_mem_arbiter
// PURPOSE
//  Downstream of the cpu core: serves both its instruction-fetch port and its data-memory port.
//  Both ports use the core's request/ready/valid handshake; each is served from one shared
//  single-port synchronous SRAM. One access in flight at a time. Data port has fixed priority.
// PARAMETERS
//  ADDR_W       12  SRAM word-address width (depth = 2**ADDR_W words of 32b)
//  RAM_LATENCY  1   SRAM read latency in cycles (1..7): ram_rdata valid RAM_LATENCY cycles after the ram_en sample edge
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous reset, active-low
//  i_req_in      in   1       instr fetch request (core instr_addr_valid_out)
//  i_addr_in     in   32      fetch byte address
//  i_ready_out   out  1       fetch request accepted (1-cycle pulse)
//  i_valid_out   out  1       i_rdata_out valid (1-cycle pulse)
//  i_rdata_out   out  32      fetched instruction
//  d_req_in      in   1       data request (core cpu_mem_valid_out)
//  d_read_en_in  in   1       read access
//  d_write_en_in in   1       write access
//  d_addr_in     in   32      data byte address
//  d_wdata_in    in   32      write data
//  d_byte_en_in  in   4       write byte enables
//  d_ready_out   out  1       data request accepted (1-cycle pulse)
//  d_valid_out   out  1       read data valid / write ack (1-cycle pulse)
//  d_rdata_out   out  32      read data
//  ram_en_out    out  1       SRAM access strobe
//  ram_we_out    out  4       SRAM byte write enables
//  ram_addr_out  out  ADDR_W  SRAM word address
//  ram_wdata_out out  32      SRAM write data
//  ram_rdata_in  in   32      SRAM read data
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state=IDLE; all outputs 0; latency counter 0.
//    Mid-access: the access is abandoned, with no late ready/valid. A write already strobed may have hit the SRAM.
//  - All outputs are registered.
//  - FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
//    IDLE: if d_req_in, grant data; else if i_req_in, grant instr; else stay.
//      On grant, latch the port and the request fields, then next cycle:
//        * the port's ready=1;
//        * ram_en=1;
//        * ram_addr=addr[ADDR_W+1:2], with the upper bits dropped (wrap) and addr[1:0] ignored;
//        * ram_we=byte_en if write else 0;
//        * ram_wdata=wdata.
//    ACCESS (1 cycle): ready, ram_en and ram_we drop to 0 at exit. Counter loads RAM_LATENCY-1.
//    WAIT: decrement until 0, then capture ram_rdata_in, or 32'h0 for writes/no-ops.
//    RESP (1 cycle): granted port valid=1 with rdata. Then -> IDLE.
//  - Latency: request sampled in IDLE at cycle 0 -> ready in cycle 1 -> valid in cycle 2+RAM_LATENCY.
//    The next grant is at the earliest in the first IDLE cycle after RESP.
//  - Requesters hold req and fields stable until valid. Fields are latched at grant; later changes are ignored.
//  - Simultaneous i_req/d_req: data served first. Instr stays pending and is granted on the next IDLE.
//  - d_read_en and d_write_en both 1: treated as write.
//    d_req with neither enable: no-op, ram_en stays 0, acked with valid and rdata 0.
//  - Write with byte_en=0: ram_en=1, ram_we=0, still acked.
//  - A req dropped before grant is never served. A req dropped after grant does not cancel the access.
//  - The non-granted port's ready/valid stay 0 throughout.
// STRUCTURE
//  - FSM state encodings and ARB_PORT_I/ARB_PORT_D as `defines in core/core_defines.v.
//  - Single module, no RTL sub-module.
//  - Bench pairs it with behavioural model sram_sp (tb only, RAM_LATENCY-parameterised).
//  - cpu.v wires instr_* to the i_ port and cpu_mem_* to the d_ port.
// TESTING
//  - Fetch, RAM_LATENCY=1: mem[0x10]=32'h00500093, i_req, addr 0x40 at cycle 0
//    -> i_ready cycle 1, i_valid with 32'h00500093 cycle 3.
//  - Write then read: d write 0x100, wdata 32'hAABBCCDD, byte_en 4'b0011
//    -> ram_we=4'b0011 at word 0x40, d_valid ack.
//    Then read 0x100 with prior 32'h11223344 -> d_rdata 32'h1122CCDD.
//  - Contention: i_req and d_req both rise at cycle 0
//    -> d_ready cycle 1, d_valid cycle 3; i_ready cycle 5 (first grant opportunity after RESP), i_valid cycle 7; no overlap.
//  - RAM_LATENCY=3: read 0x8 -> d_valid exactly cycle 5. Address 32'h0000_4004 with ADDR_W=12 -> ram_addr 12'h001 (wrap).
//  - Reset mid-WAIT: rst=0 for 1 cycle -> all outputs 0 next cycle. No valid pulse for the abandoned access.
//    A new i_req is then served normally.
//  - No-op: d_req with neither enable -> ram_en never 1, d_valid with d_rdata 0 in cycle 3.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_mem_arbiter_pkg                                                      |
// | Shared FSM / port-select types and helpers for the CPU memory arbiter.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package cpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_PORT_I = 1'b0,
    ARB_PORT_D = 1'b1
  } arb_port_t;

  // Wide enough for RAM_LATENCY-1 with RAM_LATENCY up to 7.
  localparam int LAT_CNT_W = 3;

  // Byte address to 32-bit word index; the byte offset is simply shifted out.
  function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
    return 30'(byte_addr >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_mem_arbiter                                                          |
// | Shares one single-port SRAM between the core's fetch and data ports.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_in,
  input  logic [31:0]       i_addr_in,
  output logic              i_ready_out,
  output logic              i_valid_out,
  output logic [31:0]       i_rdata_out,
  input  logic              d_req_in,
  input  logic              d_read_en_in,
  input  logic              d_write_en_in,
  input  logic [31:0]       d_addr_in,
  input  logic [31:0]       d_wdata_in,
  input  logic [3:0]        d_byte_en_in,
  output logic              d_ready_out,
  output logic              d_valid_out,
  output logic [31:0]       d_rdata_out,
  output logic              ram_en_out,
  output logic [3:0]        ram_we_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [31:0]       ram_wdata_out,
  input  logic [31:0]       ram_rdata_in
);

  localparam logic [LAT_CNT_W-1:0] c_LAT_M1 = LAT_CNT_W'(RAM_LATENCY - 1);

  arb_state_t            r_state;
  arb_port_t             r_port;
  logic                  r_zero_resp;
  logic [LAT_CNT_W-1:0]  r_lat_cnt;
  logic                  r_i_ready;
  logic                  r_i_valid;
  logic [31:0]           r_i_rdata;
  logic                  r_d_ready;
  logic                  r_d_valid;
  logic [31:0]           r_d_rdata;
  logic                  r_ram_en;
  logic [3:0]            r_ram_we;
  logic [ADDR_W-1:0]     r_ram_addr;
  logic [31:0]           r_ram_wdata;

  logic [29:0]           w_i_word;
  logic [29:0]           w_d_word;
  logic [31:0]           w_resp_data;
  logic                  w_unused_word;

  assign w_i_word      = word_index(i_addr_in);
  assign w_d_word      = word_index(d_addr_in);
  // Upper word-index bits beyond the SRAM depth wrap away.
  assign w_unused_word = ^{w_i_word, w_d_word};
  assign w_resp_data   = r_zero_resp ? 32'h0 : ram_rdata_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_port      <= ARB_PORT_I;
      r_zero_resp <= 1'b0;
      r_lat_cnt   <= '0;
      r_i_ready   <= 1'b0;
      r_i_valid   <= 1'b0;
      r_i_rdata   <= 32'h0;
      r_d_ready   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_d_rdata   <= 32'h0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 4'h0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'h0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_ram_en  <= 1'b0;
      r_ram_we  <= 4'h0;
      case (r_state)
        ST_IDLE: begin
          if (d_req_in) begin
            r_port      <= ARB_PORT_D;
            r_d_ready   <= 1'b1;
            r_ram_en    <= d_read_en_in | d_write_en_in;
            r_ram_we    <= d_write_en_in ? d_byte_en_in : 4'h0;
            r_ram_addr  <= w_d_word[ADDR_W-1:0];
            r_ram_wdata <= d_wdata_in;
            // Writes (including read+write) and no-ops answer with zero data.
            r_zero_resp <= d_write_en_in | ~d_read_en_in;
            r_state     <= ST_ACCESS;
          end else if (i_req_in) begin
            r_port      <= ARB_PORT_I;
            r_i_ready   <= 1'b1;
            r_ram_en    <= 1'b1;
            r_ram_addr  <= w_i_word[ADDR_W-1:0];
            r_ram_wdata <= 32'h0;
            r_zero_resp <= 1'b0;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_lat_cnt <= c_LAT_M1;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_lat_cnt == '0) begin
            if (r_port == ARB_PORT_D) begin
              r_d_valid <= 1'b1;
              r_d_rdata <= w_resp_data;
            end else begin
              r_i_valid <= 1'b1;
              r_i_rdata <= w_resp_data;
            end
            r_state <= ST_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign i_ready_out   = r_i_ready;
  assign i_valid_out   = r_i_valid;
  assign i_rdata_out   = r_i_rdata;
  assign d_ready_out   = r_d_ready;
  assign d_valid_out   = r_d_valid;
  assign d_rdata_out   = r_d_rdata;
  assign ram_en_out    = r_ram_en;
  assign ram_we_out    = r_ram_we;
  assign ram_addr_out  = r_ram_addr;
  assign ram_wdata_out = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_mem_arbiter                                                       |
// | Directed bench for cpu_mem_arbiter with behavioural SRAMs (L=1 and L=3). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cpu_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Latency-1 instance
  logic        i_req, d_req, d_rd, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        i_ready, i_valid, d_ready, d_valid;
  logic [31:0] i_rdata, d_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  // Latency-3 instance
  logic        i3_req, d3_req, d3_rd, d3_wr;
  logic [31:0] i3_addr, d3_addr, d3_wdata;
  logic [3:0]  d3_be;
  logic        i3_ready, i3_valid, d3_ready, d3_valid;
  logic [31:0] i3_rdata, d3_rdata;
  logic        ram3_en;
  logic [3:0]  ram3_we;
  logic [11:0] ram3_addr;
  logic [31:0] ram3_wdata, ram3_rdata;

  cpu_mem_arbiter #(.ADDR_W(12), .RAM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req_in(i_req), .i_addr_in(i_addr), .i_ready_out(i_ready), .i_valid_out(i_valid),
    .i_rdata_out(i_rdata),
    .d_req_in(d_req), .d_read_en_in(d_rd), .d_write_en_in(d_wr), .d_addr_in(d_addr),
    .d_wdata_in(d_wdata), .d_byte_en_in(d_be), .d_ready_out(d_ready), .d_valid_out(d_valid),
    .d_rdata_out(d_rdata),
    .ram_en_out(ram_en), .ram_we_out(ram_we), .ram_addr_out(ram_addr),
    .ram_wdata_out(ram_wdata), .ram_rdata_in(ram_rdata)
  );

  cpu_mem_arbiter #(.ADDR_W(12), .RAM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req_in(i3_req), .i_addr_in(i3_addr), .i_ready_out(i3_ready), .i_valid_out(i3_valid),
    .i_rdata_out(i3_rdata),
    .d_req_in(d3_req), .d_read_en_in(d3_rd), .d_write_en_in(d3_wr), .d_addr_in(d3_addr),
    .d_wdata_in(d3_wdata), .d_byte_en_in(d3_be), .d_ready_out(d3_ready), .d_valid_out(d3_valid),
    .d_rdata_out(d3_rdata),
    .ram_en_out(ram3_en), .ram_we_out(ram3_we), .ram_addr_out(ram3_addr),
    .ram_wdata_out(ram3_wdata), .ram_rdata_in(ram3_rdata)
  );

  // Behavioural SRAMs; read data is poisoned outside its valid window.
  logic        ld1_en, ld3_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem1 [0:4095];
  logic [31:0] mem3 [0:4095];
  logic        pv1;
  logic [31:0] pd1;
  logic [2:0]  pv3;
  logic [31:0] pd3 [0:2];

  always @(posedge clk) begin
    if (ld1_en) mem1[ld_addr] <= ld_data;
    else for (int b = 0; b < 4; b++)
      if (ram_en && ram_we[b]) mem1[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    pv1 <= ram_en;
    pd1 <= mem1[ram_addr];
  end
  assign ram_rdata = pv1 ? pd1 : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (ld3_en) mem3[ld_addr] <= ld_data;
    else for (int b = 0; b < 4; b++)
      if (ram3_en && ram3_we[b]) mem3[ram3_addr][8*b +: 8] <= ram3_wdata[8*b +: 8];
    pv3    <= {pv3[1:0], ram3_en};
    pd3[0] <= mem3[ram3_addr];
    pd3[1] <= pd3[0];
    pd3[2] <= pd3[1];
  end
  assign ram3_rdata = pv3[2] ? pd3[2] : 32'hDEADBEEF;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit sel3, input logic [11:0] a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    if (sel3) ld3_en = 1'b1; else ld1_en = 1'b1;
    tick();
    ld1_en = 1'b0;
    ld3_en = 1'b0;
  endtask

  typedef struct {
    bit          port_d;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          exp_en;
    logic [3:0]  exp_we;
    logic [11:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  // Single transaction on the latency-1 instance: ready at cycle 1, valid at cycle 3.
  task automatic run_txn(input vec_t v, input int idx);
    if (v.port_d) begin
      d_req = 1'b1; d_rd = v.rd; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    tick();
    chkb($sformatf("v%0d_ready", idx), v.port_d ? d_ready : i_ready, 1'b1);
    chkb($sformatf("v%0d_other_ready", idx), v.port_d ? i_ready : d_ready, 1'b0);
    chkb($sformatf("v%0d_ram_en", idx), ram_en, v.exp_en);
    chk($sformatf("v%0d_ram_we", idx), 32'(ram_we), 32'(v.exp_we));
    if (v.exp_en) chk($sformatf("v%0d_ram_addr", idx), 32'(ram_addr), 32'(v.exp_addr));
    if (v.port_d && v.wr) chk($sformatf("v%0d_ram_wdata", idx), ram_wdata, v.wdata);
    tick();
    chkb($sformatf("v%0d_ready_drop", idx), d_ready | i_ready, 1'b0);
    chkb($sformatf("v%0d_ram_en_drop", idx), ram_en, 1'b0);
    chkb($sformatf("v%0d_early_valid", idx), d_valid | i_valid, 1'b0);
    tick();
    chkb($sformatf("v%0d_valid", idx), v.port_d ? d_valid : i_valid, 1'b1);
    chkb($sformatf("v%0d_other_valid", idx), v.port_d ? i_valid : d_valid, 1'b0);
    chk($sformatf("v%0d_rdata", idx), v.port_d ? d_rdata : i_rdata, v.exp_rdata);
    d_req = 1'b0; i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    tick();
    chkb($sformatf("v%0d_valid_drop", idx), d_valid | i_valid, 1'b0);
  endtask

  initial begin
    //          port rd wr addr           wdata          be      en we      waddr    rdata
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0,    1'b1, 4'h0,    12'h010, 32'h0050_0093};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'b0011, 1'b1, 4'b0011, 12'h040, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0,    1'b1, 4'h0,    12'h040, 32'h1122_CCDD};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 4'hF, 1'b1, 4'hF,   12'h041, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0,    1'b1, 4'h0,    12'h041, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h5555_5555, 4'hF, 1'b0, 4'h0,   12'h000, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 4'h0, 1'b1, 4'h0,   12'h041, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_0107, 32'h0, 4'h0,    1'b1, 4'h0,    12'h041, 32'hCAFE_F00D};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 32'h0000_4004, 32'h0, 4'h0,    1'b1, 4'h0,    12'h001, 32'h0BAD_C0DE};

    rst = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    i3_req = 1'b0; d3_req = 1'b0; d3_rd = 1'b0; d3_wr = 1'b0;
    i3_addr = 32'h0; d3_addr = 32'h0; d3_wdata = 32'h0; d3_be = 4'h0;
    ld1_en = 1'b0; ld3_en = 1'b0; ld_addr = 12'h0; ld_data = 32'h0;
    tick();
    tick();
    load(1'b0, 12'h010, 32'h0050_0093);
    load(1'b0, 12'h040, 32'h1122_3344);
    load(1'b0, 12'h001, 32'h0BAD_C0DE);
    load(1'b1, 12'h002, 32'h3333_3333);
    load(1'b1, 12'h001, 32'h0F0F_0F0F);

    chk("rst_ctrl", 32'({i_ready, i_valid, d_ready, d_valid, ram_en, ram_we}), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_dut3_ctrl", 32'({i3_ready, i3_valid, d3_ready, d3_valid, ram3_en, ram3_we}), 32'h0);
    rst = 1'b1;
    tick();

    for (int k = 0; k < 9; k++) run_txn(vecs[k], k);

    // Contention: data first, instr granted on the IDLE cycle after RESP.
    d_req = 1'b1; d_rd = 1'b1; d_addr = 32'h0000_0100;
    i_req = 1'b1; i_addr = 32'h0000_0040;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      chkb($sformatf("cont_c%0d_d_ready", cyc), d_ready, cyc == 1);
      chkb($sformatf("cont_c%0d_d_valid", cyc), d_valid, cyc == 3);
      chkb($sformatf("cont_c%0d_i_ready", cyc), i_ready, cyc == 5);
      chkb($sformatf("cont_c%0d_i_valid", cyc), i_valid, cyc == 7);
      chkb($sformatf("cont_c%0d_ram_en", cyc), ram_en, (cyc == 1) || (cyc == 5));
      if (cyc == 3) begin
        chk("cont_d_rdata", d_rdata, 32'h1122_CCDD);
        d_req = 1'b0; d_rd = 1'b0;
      end
      if (cyc == 7) begin
        chk("cont_i_rdata", i_rdata, 32'h0050_0093);
        i_req = 1'b0;
      end
    end

    // Reset while the read sits in WAIT.
    d_req = 1'b1; d_rd = 1'b1; d_addr = 32'h0000_0104;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_ctrl", 32'({i_ready, i_valid, d_ready, d_valid, ram_en, ram_we}), 32'h0);
    chk("midrst_d_rdata", d_rdata, 32'h0);
    chk("midrst_i_rdata", i_rdata, 32'h0);
    rst = 1'b1; d_req = 1'b0; d_rd = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      chkb($sformatf("midrst_no_valid_%0d", cyc), d_valid | i_valid | d_ready, 1'b0);
    end
    run_txn(vecs[0], 100);

    // Latency 3: valid lands exactly at cycle 5; second access exercises address wrap.
    for (int t = 0; t < 2; t++) begin
      d3_req = 1'b1; d3_rd = 1'b1;
      d3_addr = (t == 0) ? 32'h0000_0008 : 32'h0000_4004;
      for (int cyc = 1; cyc <= 6; cyc++) begin
        tick();
        chkb($sformatf("l3_t%0d_c%0d_ready", t, cyc), d3_ready, cyc == 1);
        chkb($sformatf("l3_t%0d_c%0d_valid", t, cyc), d3_valid, cyc == 5);
        if (cyc == 1)
          chk($sformatf("l3_t%0d_ram_addr", t), 32'(ram3_addr), (t == 0) ? 32'h2 : 32'h1);
        if (cyc == 5) begin
          chk($sformatf("l3_t%0d_rdata", t), d3_rdata, (t == 0) ? 32'h3333_3333 : 32'h0F0F_0F0F);
          d3_req = 1'b0; d3_rd = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
